// File: rtl/ext_mem_loader.sv
// ext_mem_loader: host-side initiator for the CPU external memory ports.
// A job loads instruction memory, loads data memory, runs the CPU for a
// programmed number of cycles, then streams a window of data memory back.
// Optional build macro: LOADER_VERIFY_EN adds an instruction-memory
// read-back check (VERIFY_I state, sticky err flag).
module ext_mem_loader #(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10,
    parameter int RUN_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IMEM_AW:0]   imem_words,
    input  logic [DMEM_AW:0]   dmem_words,
    input  logic [RUN_W-1:0]   run_cycles,
    input  logic [DMEM_AW-1:0] dump_base,
    input  logic [DMEM_AW:0]   dump_words,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_data,
    output logic               out_last,
    output logic [63:0]        addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [31:0]        wdata_ext,
    input  logic [31:0]        rdata_ext,
    output logic [63:0]        addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [63:0]        wdata_ext_2,
    input  logic [63:0]        rdata_ext_2,
    output logic               cpu_enable,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CW = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_I   = 3'd1;
`ifdef LOADER_VERIFY_EN
    localparam logic [2:0] S_VERIFY_I = 3'd2;
`endif
    localparam logic [2:0] S_LOAD_D   = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_DUMP     = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [IMEM_AW:0]   iw_q;
    logic [DMEM_AW:0]   dw_q;
    logic [RUN_W-1:0]   run_q;
    logic [DMEM_AW-1:0] base_q;
    logic [DMEM_AW:0]   uw_q;
    logic               cpu_en_q;
    logic               done_q;

    // dump-side buffer state
    logic [DMEM_AW:0]   k_q;
    logic [DMEM_AW:0]   b_q;
    logic [1:0]         occ_q;
    logic               wr_q, rd_q, infl_q;
    logic [63:0]        buf_q [2];

    logic [CW-1:0]      iw_ext, dw_ext;
    logic               fire_in, fire_out, last_i, last_d, last_b;
    logic               issue, push, pop, vren;
    logic [2:0]         used_nx;
    logic [DMEM_AW-1:0] dump_addr;

    // First phase at or after 'from' whose length is non-zero (IDLE if none).
    function automatic logic [2:0] first_phase(input logic [2:0] from, input logic iw_nz,
                                               input logic dw_nz, input logic rc_nz,
                                               input logic uw_nz);
        logic [2:0] s;
        s = S_IDLE;
        if (uw_nz && from <= S_DUMP)   s = S_DUMP;
        if (rc_nz && from <= S_RUN)    s = S_RUN;
        if (dw_nz && from <= S_LOAD_D) s = S_LOAD_D;
        if (iw_nz && from <= S_LOAD_I) s = S_LOAD_I;
        return s;
    endfunction

    assign iw_ext    = CW'(iw_q);
    assign dw_ext    = CW'(dw_q);
    assign fire_in   = in_valid & in_ready;
    assign last_i    = (cnt_q + CW'(1)) == iw_ext;
    assign last_d    = (cnt_q + CW'(1)) == dw_ext;

    // Output buffer: data bypasses straight from rdata_ext_2 when the buffer is empty.
    assign out_valid = (state_q == S_DUMP) && ((occ_q != 2'd0) || infl_q);
    assign out_data  = (occ_q != 2'd0) ? buf_q[rd_q] : rdata_ext_2;
    assign fire_out  = out_valid & out_ready;
    assign last_b    = (b_q + (DMEM_AW+1)'(1)) == uw_q;
    assign out_last  = out_valid & last_b;
    assign used_nx   = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, fire_out};
    assign issue     = (state_q == S_DUMP) && (k_q != uw_q) && (used_nx < 3'd2);
    assign push      = infl_q && !((occ_q == 2'd0) && out_ready);
    assign pop       = (occ_q != 2'd0) && out_ready;
    assign dump_addr = base_q + k_q[DMEM_AW-1:0];

    assign cpu_enable = cpu_en_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    // Next-state logic; zero-length phases are skipped in the same transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)
                state_d = first_phase(S_LOAD_I, |imem_words, |dmem_words,
                                      |run_cycles, |dump_words);
            S_LOAD_I: if (fire_in && last_i)
`ifdef LOADER_VERIFY_EN
                state_d = S_VERIFY_I;
            S_VERIFY_I: if (cnt_q == iw_ext)
`endif
                state_d = first_phase(S_LOAD_D, 1'b0, |dw_q, |run_q, |uw_q);
            S_LOAD_D: if (fire_in && last_d)
                state_d = first_phase(S_RUN, 1'b0, 1'b0, |run_q, |uw_q);
            S_RUN: if (run_q == RUN_W'(1))
                state_d = first_phase(S_DUMP, 1'b0, 1'b0, 1'b0, |uw_q);
            S_DUMP: if (fire_out && last_b)
                state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // External port drive: everything is 0 outside the phase that owns a port.
    always_comb begin
        in_ready    = 1'b0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        addr_ext    = '0;
        wdata_ext   = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = '0;
        wdata_ext_2 = '0;
        case (state_q)
            S_LOAD_I: begin
                in_ready  = 1'b1;
                wen_ext   = in_valid;
                addr_ext  = {{(64-IMEM_AW-2){1'b0}}, cnt_q[IMEM_AW-1:0], 2'b00};
                wdata_ext = in_data[31:0];
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY_I: begin
                ren_ext  = vren;
                addr_ext = {{(64-IMEM_AW-2){1'b0}}, cnt_q[IMEM_AW-1:0], 2'b00};
            end
`endif
            S_LOAD_D: begin
                in_ready    = 1'b1;
                wen_ext_2   = in_valid;
                addr_ext_2  = {{(64-DMEM_AW-3){1'b0}}, cnt_q[DMEM_AW-1:0], 3'b000};
                wdata_ext_2 = in_data;
            end
            S_DUMP: begin
                ren_ext_2  = issue;
                addr_ext_2 = {{(64-DMEM_AW-3){1'b0}}, dump_addr, 3'b000};
            end
            default: ;
        endcase
    end

    // Main control: FSM, job parameter latch, phase counter, run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            iw_q     <= '0;
            dw_q     <= '0;
            run_q    <= '0;
            base_q   <= '0;
            uw_q     <= '0;
            cpu_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= (state_d == S_RUN);
            done_q   <= (state_q != S_IDLE) && (state_d == S_IDLE);
            if (state_d != state_q)
                cnt_q <= '0;
            else if (fire_in || vren)
                cnt_q <= cnt_q + CW'(1);
            if (state_q == S_IDLE && start) begin
                iw_q   <= imem_words;
                dw_q   <= dmem_words;
                run_q  <= run_cycles;
                base_q <= dump_base;
                uw_q   <= dump_words;
            end else if (state_q == S_RUN) begin
                run_q <= run_q - RUN_W'(1);
            end
        end
    end

    // Dump control: issued/accepted counters and buffer occupancy, cleared outside DUMP.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_DUMP) begin
            k_q    <= '0;
            b_q    <= '0;
            occ_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            infl_q <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue)    k_q <= k_q + (DMEM_AW+1)'(1);
            if (fire_out) b_q <= b_q + (DMEM_AW+1)'(1);
            if (push)     wr_q <= ~wr_q;
            if (pop)      rd_q <= ~rd_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Dump buffer storage (data only, no reset).
    always_ff @(posedge clk) begin
        if (state_q == S_DUMP && push)
            buf_q[wr_q] <= rdata_ext_2;
    end

`ifdef LOADER_VERIFY_EN
    logic [31:0] chk_w_q, chk_r_q;
    logic        vld_q, err_q;

    assign vren = (state_q == S_VERIFY_I) && (cnt_q != iw_ext);
    assign err  = err_q;

    // Read-back check: fold written and read words, flag a mismatch at VERIFY_I exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_w_q <= '0;
            chk_r_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q <= vren;
            if (state_q == S_IDLE && start) begin
                chk_w_q <= '0;
                chk_r_q <= '0;
                err_q   <= 1'b0;
            end else begin
                if (state_q == S_LOAD_I && fire_in)
                    chk_w_q <= chk_w_q ^ in_data[31:0];
                if (vld_q)
                    chk_r_q <= chk_r_q ^ rdata_ext;
                if (state_q == S_VERIFY_I && cnt_q == iw_ext &&
                    (chk_r_q ^ rdata_ext) != chk_w_q)
                    err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata_ext;
    assign vren = 1'b0;
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader: job table plus hand-written corner sequences.
module tb_ext_mem_loader;
    localparam int IMEM_AW = 9;
    localparam int DMEM_AW = 10;
    localparam int RUN_W   = 32;
`ifdef LOADER_VERIFY_EN
    localparam int VON = 1;
`else
    localparam int VON = 0;
`endif

    logic               clk, rst, start;
    logic [IMEM_AW:0]   imem_words;
    logic [DMEM_AW:0]   dmem_words;
    logic [RUN_W-1:0]   run_cycles;
    logic [DMEM_AW-1:0] dump_base;
    logic [DMEM_AW:0]   dump_words;
    logic               in_valid, in_ready, out_valid, out_ready, out_last;
    logic [63:0]        in_data, out_data;
    logic [63:0]        addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic               wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0]        wdata_ext, rdata_ext;
    logic               cpu_enable, busy, done, err;

    ext_mem_loader #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .RUN_W(RUN_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_words(dump_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with 1-cycle read latency; data memory preloaded with a pattern on reset.
    logic [31:0] imem [0:511];
    logic [63:0] dmem [0:1023];
    logic        flip1;
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 1024; a++) dmem[a] <= 64'hD00D_0000_0000_0000 | 64'(a);
            for (int a = 0; a < 512; a++)  imem[a] <= 32'h0;
        end else begin
            if (wen_ext)   imem[addr_ext[10:2]] <= wdata_ext;
            if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        end
        if (ren_ext)
            rdata_ext <= imem[addr_ext[10:2]] ^ ((flip1 && addr_ext[10:2] == 9'd1) ? 32'h100 : 32'h0);
        if (ren_ext_2)
            rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    int checks, errors;
    int n_cyc, n_cpu, n_bad, n_wen2, n_ren, tot_ren, n_done, done_cyc, n_last, last_idx;
    int n_hi, n_unstable, first_ren_cyc, last_beat_cyc, rdy_lo, sidx;
    logic        held_v;
    logic [63:0] held;
    logic [63:0] stream [$];
    logic [63:0] wen_addr [$];
    logic [63:0] wen_data [$];
    int          wen_cyc  [$];
    logic [63:0] ren2_addr [$];
    logic [63:0] beat [$];

    typedef struct {
        int iw, dw, rc, base, uw;
        int e_wen, e_wen2, e_cpu, e_beats, e_cyc;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        n_cyc = 0; n_cpu = 0; n_bad = 0; n_wen2 = 0; n_ren = 0; n_done = 0; done_cyc = 0;
        n_last = 0; last_idx = -1; n_hi = 0; n_unstable = 0; first_ren_cyc = -1;
        last_beat_cyc = -1; sidx = 0; held_v = 1'b0; held = '0;
        wen_addr.delete(); wen_data.delete(); wen_cyc.delete(); ren2_addr.delete(); beat.delete();
    endtask

    // One clock: drive, sample at the falling edge, then advance past the rising edge.
    task automatic step();
        in_data   = (sidx < stream.size()) ? stream[sidx] : 64'h0;
        out_ready = (rdy_lo == 0);
        @(negedge clk);
        n_cyc++;
        if (cpu_enable) begin
            n_cpu++;
            if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) n_bad++;
        end
        if (addr_ext[63:11] != '0 || addr_ext_2[63:13] != '0) n_hi++;
        if (wen_ext) begin
            wen_addr.push_back(addr_ext);
            wen_data.push_back(64'(wdata_ext));
            wen_cyc.push_back(n_cyc);
        end
        if (wen_ext_2) n_wen2++;
        if (ren_ext) begin n_ren++; tot_ren++; end
        if (ren_ext_2) begin
            if (first_ren_cyc < 0) first_ren_cyc = n_cyc;
            ren2_addr.push_back(addr_ext_2);
        end
        if (out_valid) begin
            if (held_v && out_data != held) n_unstable++;
            held_v = !out_ready;
            held   = out_data;
            if (out_ready) begin
                if (out_last) begin n_last++; last_idx = beat.size(); end
                beat.push_back(out_data);
                last_beat_cyc = n_cyc;
            end
            if (rdy_lo > 0) rdy_lo--;
        end else begin
            held_v = 1'b0;
        end
        if (done) begin
            if (n_done == 0) done_cyc = n_cyc;
            n_done++;
        end
        if (in_valid && in_ready) sidx++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int iw, input int dw, input int rc, input int base,
                           input int uw, input int rlo, input int budget);
        clear_logs();
        imem_words = (IMEM_AW+1)'(iw);
        dmem_words = (DMEM_AW+1)'(dw);
        run_cycles = RUN_W'(rc);
        dump_base  = DMEM_AW'(base);
        dump_words = (DMEM_AW+1)'(uw);
        rdy_lo     = rlo;
        start      = 1'b1;
        step();
        start      = 1'b0;
        imem_words = '1; dmem_words = '1; run_cycles = '1; dump_base = '1; dump_words = '1;
        n_cyc = 0;
        for (int c = 0; c < budget && n_done == 0; c++) step();
        if (n_done == 0) chk("job_done_timeout", 64'(n_done), 64'd1);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; tot_ren = 0; rdy_lo = 0; flip1 = 1'b0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        imem_words = '0; dmem_words = '0; run_cycles = '0; dump_base = '0; dump_words = '0;
        stream.push_back(64'hABCD_0000_0000_0013);
        stream.push_back(64'h1234_5678_0010_0093);
        stream.push_back(64'hCAFE_F00D_0020_8113);
        stream.push_back(64'h0F0F_0F0F_0000_0044);
        tbl[0] = '{3, 0, 0, 0,    0, 3, 0, 0, 0, 4};
        tbl[1] = '{0, 2, 0, 0,    2, 0, 2, 0, 2, 6};
        tbl[2] = '{0, 0, 7, 0,    0, 0, 0, 7, 0, 8};
        tbl[3] = '{2, 1, 3, 5,    3, 2, 1, 3, 3, 11};
        tbl[4] = '{0, 0, 0, 1022, 4, 0, 0, 0, 4, 6};
        clear_logs();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, cpu_enable, in_ready, out_valid, out_last, err}), 64'd0);
        chk("reset_ext", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}) | addr_ext | addr_ext_2, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1;

        // reset in the middle of RUN
        clear_logs();
        imem_words = 10'd2; dmem_words = '0; run_cycles = 32'd100; dump_base = '0; dump_words = '0;
        start = 1'b1; step(); start = 1'b0;
        for (int c = 0; c < 60 && n_cpu < 10; c++) step();
        chk("rst_run_reached", 64'(n_cpu), 64'd10);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_run_outputs", 64'({cpu_enable, busy, done, wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (5) step();
        chk("rst_run_no_done", 64'(n_done), 64'd0);

        // dump window wrapping past the top of data memory
        run_job(0, 0, 0, 1022, 4, 0, 40);
        chk("wrap_nreads", 64'(ren2_addr.size()), 64'd4);
        chk("wrap_addr0", ren2_addr[0], 64'h1FF0);
        chk("wrap_addr1", ren2_addr[1], 64'h1FF8);
        chk("wrap_addr2", ren2_addr[2], 64'h0);
        chk("wrap_addr3", ren2_addr[3], 64'h8);
        chk("wrap_data0", beat[0], 64'hD00D_0000_0000_03FE);
        chk("wrap_data2", beat[2], 64'hD00D_0000_0000_0000);
        chk("wrap_data3", beat[3], 64'hD00D_0000_0000_0001);
        chk("wrap_window", 64'(last_beat_cyc - first_ren_cyc + 1), 64'd5);
        chk("wrap_last_idx", 64'(last_idx), 64'd3);

        // job table
        foreach (tbl[i]) begin
            run_job(tbl[i].iw, tbl[i].dw, tbl[i].rc, tbl[i].base, tbl[i].uw, 0, 200);
            chk($sformatf("tbl%0d_wen", i), 64'(wen_addr.size()), 64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_wen2", i), 64'(n_wen2), 64'(tbl[i].e_wen2));
            chk($sformatf("tbl%0d_cpu", i), 64'(n_cpu), 64'(tbl[i].e_cpu));
            chk($sformatf("tbl%0d_beats", i), 64'(beat.size()), 64'(tbl[i].e_beats));
            chk($sformatf("tbl%0d_cycles", i), 64'(done_cyc),
                64'(tbl[i].e_cyc + VON * ((tbl[i].iw != 0) ? tbl[i].iw + 1 : 0)));
            chk($sformatf("tbl%0d_done_once", i), 64'(n_done), 64'd1);
            chk($sformatf("tbl%0d_last", i), 64'(n_last), 64'((tbl[i].uw != 0) ? 1 : 0));
            chk($sformatf("tbl%0d_ext_in_run", i), 64'(n_bad), 64'd0);
            chk($sformatf("tbl%0d_addr_hi", i), 64'(n_hi), 64'd0);
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'd0);
        end

        // basic instruction load: three back-to-back beats
        run_job(3, 0, 0, 0, 0, 0, 40);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("load_addr%0d", i), wen_addr[i], 64'(4 * i));
            chk($sformatf("load_data%0d", i), wen_data[i], 64'(stream[i][31:0]));
        end
        chk("load_consecutive", 64'(wen_cyc[2] - wen_cyc[0]), 64'd2);

        // backpressure on the dump stream with RUN skipped
        run_job(0, 2, 0, 0, 2, 5, 60);
        chk("bp_cpu", 64'(n_cpu), 64'd0);
        chk("bp_beats", 64'(beat.size()), 64'd2);
        chk("bp_data0", beat[0], stream[0]);
        chk("bp_data1", beat[1], stream[1]);
        chk("bp_stable", 64'(n_unstable), 64'd0);
        chk("bp_last_idx", 64'(last_idx), 64'd1);
        chk("bp_done", 64'(n_done), 64'd1);
        chk("bp_cycles", 64'(done_cyc), 64'd11);

`ifdef LOADER_VERIFY_EN
        flip1 = 1'b1;
        run_job(3, 0, 0, 0, 0, 0, 40);
        chk("verify_reads", 64'(n_ren), 64'd3);
        @(negedge clk);
        chk("verify_err_set", 64'(err), 64'd1);
        @(posedge clk); #1;
        repeat (3) step();
        @(negedge clk);
        chk("verify_err_sticky", 64'(err), 64'd1);
        @(posedge clk); #1;
        flip1 = 1'b0;
        run_job(3, 0, 0, 0, 0, 0, 40);
        @(negedge clk);
        chk("verify_err_clean", 64'(err), 64'd0);
        @(posedge clk); #1;
`else
        chk("no_verify_ren", 64'(tot_ren), 64'd0);
        chk("no_verify_err", 64'(err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_mem_loader.md
Name: ext_mem_loader

Overview:
- Host-side initiator for the CPU's external memory ports (instruction-memory ext port and data-memory ext port).
- Sequence per job:
  - stream a program into instruction memory
  - stream initial data into data memory
  - assert CPU enable for a programmed number of cycles
  - stream a window of data memory back out to the host
- Sits between the testbench/host link and the cpu top-level ext_* pins; it is the only driver of those pins.

Parameters:
- IMEM_AW, 9, instruction memory word-address width (max 512 words).
- DMEM_AW, 10, data memory word-address width (max 1024 words).
- RUN_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- imem_words  in  IMEM_AW+1  instruction words to load (0 = skip)
- dmem_words  in  DMEM_AW+1  data words to load (0 = skip)
- run_cycles  in  RUN_W  cycles to hold cpu_enable high (0 = skip)
- dump_base  in  DMEM_AW  first data word to read back
- dump_words  in  DMEM_AW+1  words to read back (0 = skip)
- in_valid / in_ready  in / out  1  load stream handshake
- in_data  in  64  load word; IMEM phase uses [31:0]
- out_valid / out_ready  out / in  1  dump stream handshake
- out_data  out  64  dump word
- out_last  out  1  high on the final dump beat
- addr_ext  out  64  IMEM ext byte address
- wen_ext, ren_ext  out  1  IMEM ext write/read enable
- wdata_ext  out  32  IMEM ext write data
- rdata_ext  in  32  IMEM ext read data
- addr_ext_2  out  64  DMEM ext byte address
- wen_ext_2, ren_ext_2  out  1  DMEM ext write/read enable
- wdata_ext_2  out  64  DMEM ext write data
- rdata_ext_2  in  64  DMEM ext read data
- cpu_enable  out  1  drives cpu enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entering IDLE from a job
- err  out  1  sticky verify failure (see Optional Feature)

Behaviour:
- Reset: synchronous, on rising clk while rst=1.
  - All outputs 0, FSM to IDLE, counters cleared.
  - rst mid-job aborts immediately: next cycle cpu_enable=0 and all ext enables=0. No done pulse.
- Job parameters are latched on start; inputs may change afterwards.
- FSM: IDLE -> LOAD_I -> LOAD_D -> RUN -> DUMP -> IDLE. A phase with length 0 is skipped in the same transition.
- LOAD_I:
  - in_ready=1.
  - Each in_valid&in_ready beat drives, combinationally in that cycle: wen_ext=1, addr_ext=4*i, wdata_ext=in_data[31:0]; i increments.
  - Exit after beat imem_words-1.
- LOAD_D: same rules on the DMEM port, with addr_ext_2=8*j and wdata_ext_2=in_data.
- In all states other than LOAD_I/LOAD_D, in_ready=0.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles; registered output, high starting the cycle after entry.
  - Ext enables held 0 throughout.
  - Down-counter; exit when it reaches 0.
- DUMP:
  - DMEM ext read latency is fixed at 1 cycle: rdata_ext_2 is valid the cycle after ren_ext_2=1.
  - ren_ext_2=1 with addr_ext_2=8*(dump_base+k).
  - Captured data goes into a 2-entry output buffer; a read is issued only when a buffer slot is guaranteed free, counting the in-flight read.
  - out_valid stays high and out_data stable until out_ready.
  - Zero bubbles when out_ready is held high.
  - Word address wraps modulo 2^DMEM_AW.
  - Exit after the last beat handshakes; out_last is high on that beat only.
- done pulses in the cycle IDLE is re-entered.
- start while busy is ignored.
- Addresses beyond memory depth: word counters wrap at 2^IMEM_AW / 2^DMEM_AW. Lengths larger than depth overwrite from word 0.
- The upper address bits of addr_ext / addr_ext_2 beyond the word index are always 0.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- Defined:
  - During LOAD_I, XOR-fold every written word into chk_w.
  - After LOAD_I, a VERIFY_I state reads back all imem_words via ren_ext (1-cycle latency) and XOR-folds them into chk_r.
  - On mismatch, err is set (sticky until rst or the next accepted start); the job still continues.
  - Adds imem_words+1 cycles to the job.
- Undefined: no VERIFY_I state, err tied to 0, ren_ext always 0.

Test Plan:
- Reset mid-RUN:
  - Stimulus: start with imem=2, dmem=0, run=100; assert rst after 10 RUN cycles.
  - Response: next cycle cpu_enable=0, busy=0, no done pulse; all ext enables 0.
- Basic load:
  - Stimulus: imem_words=3, words 0x00000013, 0x00100093, 0x00208113, in_valid held high.
  - Response: wen_ext on 3 consecutive cycles at addr 0x0, 0x4, 0x8 with matching wdata_ext.
- Backpressure and skip:
  - Stimulus: dmem_words=2, dump_words=2, run_cycles=0, out_ready low for 5 cycles then high.
  - Response: RUN skipped; out_data holds the first word until handshake; out_last on beat 2; done pulses once.
- Run window:
  - Stimulus: run_cycles=7.
  - Response: cpu_enable high for exactly 7 cycles, with no ext enable active during those cycles.
- Dump wrap:
  - Stimulus: dump_base=1022, dump_words=4.
  - Response: reads at word addresses 1022, 1023, 0, 1 (byte 0x1FF0, 0x1FF8, 0x0, 0x8); 4 beats in 5 cycles with out_ready high.
- Verify (LOADER_VERIFY_EN):
  - Stimulus: model returns bit-flipped rdata_ext on word 1.
  - Response: err=1 after VERIFY_I and remains 1 after done.
  - With a correct model, err=0.
